// File: rtl/mult_pkg.sv
// Shared definitions for the EX-stage pipelined multiplier: op codes and
// decode helpers used by the datapath.
package mult_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    MUL   = 3'd2,
    MADD  = 3'd3,
    MADDU = 3'd4,
    MSUB  = 3'd5,
    MSUBU = 3'd6
  } mul_op_e;

  // Bit n is set when op code n subtracts the product from {hi,lo}.
  localparam logic [7:0] ACC_SUB = 8'b0110_0000;

  function automatic logic is_signed_op(input logic [2:0] op);
    return op inside {MULT, MUL, MADD, MSUB};
  endfunction

  function automatic logic is_acc_op(input logic [2:0] op);
    return op inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_sub_op(input logic [2:0] op);
    return ACC_SUB[op];
  endfunction

endpackage

// File: rtl/mult_pipe_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiplier (slave).
interface mult_pipe_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) ();

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              op;
  logic [TAG_WIDTH-1:0]    tag_in;
  logic [DATA_WIDTH-1:0]   operand_1;
  logic [DATA_WIDTH-1:0]   operand_2;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]    tag_out;
  logic                    busy;

  modport master (
    output flush, in_valid, op, tag_in, operand_1, operand_2, hi, lo, out_ready,
    input  in_ready, out_valid, result, tag_out, busy
  );

  modport slave (
    input  flush, in_valid, op, tag_in, operand_1, operand_2, hi, lo, out_ready,
    output in_ready, out_valid, result, tag_out, busy
  );

endinterface

// File: rtl/mult_pipe_ctrl.sv
// Valid/stall/flush chain for the multiplier pipeline; emits one load enable
// per stage so the datapath registers only move when their op moves.
module mult_pipe_ctrl #(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              in_ready,
  output logic [STAGES-1:0] load_en,
  output logic              out_valid,
  output logic              busy
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] advance;
  logic              accept;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    advance = '0;
    valid_d = valid_q;
    load_en = '0;

    // A stage can move whenever there is a bubble at or below it, or the
    // consumer drains the output stage this cycle.
    for (int k = 0; k < STAGES; k++) begin
      advance[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) advance[k] = 1'b1;
      end
    end

    in_ready = rst && !flush && advance[0];
    accept   = in_valid && in_ready;

    load_en[0] = accept;
    if (advance[0]) valid_d[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      load_en[k] = advance[k] && valid_q[k-1];
      if (advance[k]) valid_d[k] = valid_q[k-1];
    end

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  assign out_valid = valid_q[STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/mult_pipe_unit.sv
// Pipelined MIPS multiply/multiply-accumulate unit: the full 2W result is
// formed at issue and carried through STAGES retimable registers.
module mult_pipe_unit
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3,
  parameter int TAG_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  mult_pipe_unit_if.slave io
);

  localparam int RW = 2 * DATA_WIDTH;

  logic [STAGES-1:0]                load_en;
  logic [RW-1:0]                    op_a_ext, op_b_ext, product, acc, res_in;
  logic [STAGES-1:0][RW-1:0]        res_d, res_q;
  logic [STAGES-1:0][TAG_WIDTH-1:0] tag_d, tag_q;

  mult_pipe_ctrl #(.STAGES(STAGES)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (io.flush),
    .in_valid  (io.in_valid),
    .out_ready (io.out_ready),
    .in_ready  (io.in_ready),
    .load_en   (load_en),
    .out_valid (io.out_valid),
    .busy      (io.busy)
  );

  // Extending both operands to 2W lets one unsigned multiply serve signed and
  // unsigned ops; the low 2W bits are the exact product modulo 2^(2W).
  always_comb begin
    if (is_signed_op(io.op)) begin
      op_a_ext = {{DATA_WIDTH{io.operand_1[DATA_WIDTH-1]}}, io.operand_1};
      op_b_ext = {{DATA_WIDTH{io.operand_2[DATA_WIDTH-1]}}, io.operand_2};
    end else begin
      op_a_ext = {{DATA_WIDTH{1'b0}}, io.operand_1};
      op_b_ext = {{DATA_WIDTH{1'b0}}, io.operand_2};
    end
    product = op_a_ext * op_b_ext;
    acc     = {io.hi, io.lo};
    res_in  = product;
    if (is_acc_op(io.op)) begin
      res_in = is_sub_op(io.op) ? acc - product : acc + product;
    end
  end

  always_comb begin
    res_d    = res_q;
    tag_d    = tag_q;
    res_d[0] = res_in;
    tag_d[0] = io.tag_in;
    for (int k = 1; k < STAGES; k++) begin
      res_d[k] = res_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (load_en[k]) begin
        res_q[k] <= res_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
    // NOTE: inner payload registers are qualified by the valid chain and are
    // left unreset; only the visible output stage is cleared.
    if (!rst) begin
      res_q[STAGES-1] <= '0;
      tag_q[STAGES-1] <= '0;
    end
  end

  assign io.result  = res_q[STAGES-1];
  assign io.tag_out = tag_q[STAGES-1];

endmodule
